// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer (fetch side of the 8-bit CPU).
package ps_pkg;

  typedef enum logic [2:0] {
    RST   = 3'd0,
    REQ   = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    RETRY = 3'd4
  } ps_state_t;

  localparam logic [7:0] BUBBLE_DEFAULT = 8'hC8;
  localparam int         PC_W           = 8;
  localparam int         CNT_W          = 4;

  // A jump keeps the current 16-byte page and replaces only the low nibble.
  function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0] pc_cur,
                                                  input logic [3:0]      nibble);
    return {pc_cur[PC_W-1:4], nibble};
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Program memory read bus: level request held until the memory answers with ready.
interface program_sequencer_if;
  import ps_pkg::*;

  logic [PC_W-1:0] pm_addr;
  logic            pm_rd;
  logic            pm_ready;
  logic [7:0]      pm_data;

  modport master (output pm_addr, output pm_rd, input pm_ready, input pm_data);
  modport slave  (input pm_addr, input pm_rd, output pm_ready, output pm_data);

endinterface

// File: rtl/program_sequencer_reset_sync.sv
// Two-flop reset synchroniser: asserts immediately with the system reset, releases
// on the second rising clock edge after it falls.
module reset_sync (
  input  logic clk,
  input  logic reset,
  output logic sync_reset
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_reset = sync_q[1];

endmodule

// File: rtl/program_sequencer.sv
// Fetch unit: owns the PC, reads program bytes over the ready handshake, issues each
// byte to the decoder for one clock and resolves jmp / jmp_nz in the EXEC slot.
module program_sequencer
  import ps_pkg::*;
#(
  parameter logic [7:0] BUBBLE     = BUBBLE_DEFAULT,
  parameter int         WAIT_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 jmp,
  input  logic                 jmp_nz,
  input  logic                 dont_jmp,
  input  logic [3:0]           ir_nibble,
  program_sequencer_if.master  pm,
  output logic [7:0]           next_instr,
  output logic                 instr_valid,
  output logic                 sync_reset,
  output logic [PC_W-1:0]      pc,
  output logic [PC_W-1:0]      from_PS,
  output logic                 fetch_err
);

  localparam logic [CNT_W-1:0] WAIT_LIMIT_C = CNT_W'(WAIT_LIMIT);

  ps_state_t        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic [7:0]       next_instr_q, next_instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fetch_err_q, fetch_err_d;
  logic             pm_rd_c;
  logic             take_jump;

  reset_sync u_reset_sync (
    .clk        (clk),
    .reset      (reset),
    .sync_reset (sync_reset)
  );

  assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);
  assign take_jump    = jmp || (jmp_nz && !dont_jmp);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wait_cnt_d    = wait_cnt_q;
    next_instr_d  = next_instr_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    pm_rd_c       = 1'b0;

    case (state_q)
      RST: begin
        if (!sync_reset) begin
          state_d = REQ;
        end
      end

      REQ: begin
        pm_rd_c = 1'b1;
        if (pm.pm_ready) begin
          next_instr_d  = pm.pm_data;
          instr_valid_d = 1'b1;
          wait_cnt_d    = '0;
          state_d       = ISSUE;
        end else if (wait_cnt_inc == WAIT_LIMIT_C) begin
          // Give up on this attempt: flag it, drop the request for a cycle, retry.
          fetch_err_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = RETRY;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      ISSUE: begin
        next_instr_d  = BUBBLE;
        instr_valid_d = 1'b0;
        state_d       = EXEC;
      end

      EXEC: begin
        if (take_jump) begin
          pc_d = jump_target(pc_q, ir_nibble);
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
        state_d = REQ;
      end

      RETRY: begin
        state_d = REQ;
      end

      default: begin
        state_d = RST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RST;
      pc_q          <= '0;
      wait_cnt_q    <= '0;
      next_instr_q  <= BUBBLE;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wait_cnt_q    <= wait_cnt_d;
      next_instr_q  <= next_instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign pm.pm_addr  = pc_q;
  assign pm.pm_rd    = pm_rd_c;
  assign pc          = pc_q;
  assign from_PS     = pc_q;
  assign next_instr  = next_instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus randomized fetches
// compared against a PC/fetch model built from the sequencer's architectural rules.
module tb_program_sequencer;

  localparam logic [7:0] BUB = 8'hC8;

  logic       clk;
  logic       reset;
  logic       jmp;
  logic       jmp_nz;
  logic       dont_jmp;
  logic [3:0] ir_nibble;
  logic [7:0] next_instr;
  logic       instr_valid;
  logic       sync_reset;
  logic [7:0] pc;
  logic [7:0] from_PS;
  logic       fetch_err;

  program_sequencer_if pm_if ();

  program_sequencer #(
    .BUBBLE     (8'hC8),
    .WAIT_LIMIT (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .jmp         (jmp),
    .jmp_nz      (jmp_nz),
    .dont_jmp    (dont_jmp),
    .ir_nibble   (ir_nibble),
    .pm          (pm_if.master),
    .next_instr  (next_instr),
    .instr_valid (instr_valid),
    .sync_reset  (sync_reset),
    .pc          (pc),
    .from_PS     (from_PS),
    .fetch_err   (fetch_err)
  );

  int         n_checks;
  int         n_fail;
  int         cycle_cnt;
  int         issue_cyc;
  logic [7:0] model_pc;
  logic       exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with reset high; leaves at the falling edge of the first REQ cycle.
  task automatic releaseReset();
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_pm_rd", {7'b0, pm_if.pm_rd}, 8'h00);
    checkOutput("rst_next_instr", next_instr, BUB);
    checkOutput("rst_instr_valid", {7'b0, instr_valid}, 8'h00);
    checkOutput("rst_fetch_err", {7'b0, fetch_err}, 8'h00);
    checkOutput("rst_sync_reset", {7'b0, sync_reset}, 8'h01);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rel_sync_edge1", {7'b0, sync_reset}, 8'h01);
    checkOutput("rel_pm_rd_edge1", {7'b0, pm_if.pm_rd}, 8'h00);
    checkOutput("rel_instr_edge1", next_instr, BUB);
    @(negedge clk);
    checkOutput("rel_sync_edge2", {7'b0, sync_reset}, 8'h00);
    checkOutput("rel_pm_rd_edge2", {7'b0, pm_if.pm_rd}, 8'h00);
    checkOutput("rel_instr_edge2", next_instr, BUB);
    @(negedge clk);
    checkOutput("first_pm_rd", {7'b0, pm_if.pm_rd}, 8'h01);
    checkOutput("first_pm_addr", pm_if.pm_addr, 8'h00);
    checkOutput("first_instr", next_instr, BUB);
    model_pc = 8'h00;
    exp_err  = 1'b0;
  endtask

  // One full instruction: entered and left at the falling edge of a REQ cycle.
  task automatic applyStimulus(input logic [7:0] data, input int waits, input logic j,
                               input logic jnz, input logic dj, input logic [3:0] nib);
    checkOutput("req_pm_rd", {7'b0, pm_if.pm_rd}, 8'h01);
    checkOutput("req_pm_addr", pm_if.pm_addr, model_pc);
    for (int w = 0; w < waits; w++) begin
      pm_if.pm_ready = 1'b0;
      pm_if.pm_data  = 8'($urandom);
      jmp            = 1'($urandom);
      jmp_nz         = 1'($urandom);
      ir_nibble      = 4'($urandom);
      @(negedge clk);
      checkOutput("wait_pm_rd", {7'b0, pm_if.pm_rd}, 8'h01);
      checkOutput("wait_valid", {7'b0, instr_valid}, 8'h00);
      checkOutput("wait_instr", next_instr, BUB);
    end
    pm_if.pm_ready = 1'b1;
    pm_if.pm_data  = data;
    @(negedge clk);
    issue_cyc      = cycle_cnt;
    pm_if.pm_ready = 1'b0;
    pm_if.pm_data  = 8'($urandom);
    checkOutput("issue_instr", next_instr, data);
    checkOutput("issue_valid", {7'b0, instr_valid}, 8'h01);
    checkOutput("issue_pm_rd", {7'b0, pm_if.pm_rd}, 8'h00);
    jmp       = 1'($urandom);
    jmp_nz    = 1'($urandom);
    dont_jmp  = 1'($urandom);
    ir_nibble = 4'($urandom);
    @(negedge clk);
    checkOutput("exec_instr", next_instr, BUB);
    checkOutput("exec_valid", {7'b0, instr_valid}, 8'h00);
    checkOutput("exec_pc", pc, model_pc);
    checkOutput("exec_fetch_err", {7'b0, fetch_err}, {7'b0, exp_err});
    jmp       = j;
    jmp_nz    = jnz;
    dont_jmp  = dj;
    ir_nibble = nib;
    @(negedge clk);
    jmp    = 1'b0;
    jmp_nz = 1'b0;
    if (j || (jnz && !dj)) model_pc = {model_pc[7:4], nib};
    else                   model_pc = 8'((int'(model_pc) + 1) % 256);
    checkOutput("next_pm_addr", pm_if.pm_addr, model_pc);
    checkOutput("next_from_PS", from_PS, model_pc);
  endtask

  initial begin
    logic [7:0] rom_seq [4];
    int         prev_issue;
    int         guard;

    n_checks       = 0;
    n_fail         = 0;
    cycle_cnt      = 0;
    issue_cyc      = 0;
    model_pc       = 8'h00;
    exp_err        = 1'b0;
    reset          = 1'b1;
    jmp            = 1'b0;
    jmp_nz         = 1'b0;
    dont_jmp       = 1'b0;
    ir_nibble      = 4'h0;
    pm_if.pm_ready = 1'b0;
    pm_if.pm_data  = 8'h00;
    rom_seq        = '{8'h41, 8'h52, 8'h63, 8'h74};

    repeat (2) @(negedge clk);
    $display("[TB] reset release");
    releaseReset();

    $display("[TB] sequential zero-wait fetch");
    prev_issue = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rom_seq[i], 0, 1'b0, 1'b0, 1'b0, 4'h0);
      if (i > 0) checkOutput("issue_spacing", 8'(issue_cyc - prev_issue), 8'd3);
      prev_issue = issue_cyc;
    end
    checkOutput("seq_pc", pc, 8'h04);

    $display("[TB] randomized fetches");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom), $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
                    1'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("[TB] unconditional jump at 0x35");
    guard = 0;
    while (model_pc != 8'h35 && guard < 300) begin
      applyStimulus(8'($urandom), $urandom_range(0, 2), 1'b0, 1'b0, 1'($urandom), 4'($urandom));
      guard++;
    end
    checkOutput("reach_35", pc, 8'h35);
    applyStimulus(8'h90, 0, 1'b1, 1'b0, 1'b0, 4'hA);
    checkOutput("jmp_addr", pm_if.pm_addr, 8'h3A);

    $display("[TB] conditional jump at 0x10");
    guard = 0;
    while (model_pc != 8'h10 && guard < 300) begin
      applyStimulus(8'($urandom), 0, 1'b0, 1'b0, 1'($urandom), 4'($urandom));
      guard++;
    end
    checkOutput("reach_10", pc, 8'h10);
    applyStimulus(8'hA1, 0, 1'b0, 1'b1, 1'b1, 4'h7);
    checkOutput("jnz_not_taken", pm_if.pm_addr, 8'h11);
    applyStimulus(8'hA2, 0, 1'b0, 1'b1, 1'b0, 4'h2);
    checkOutput("jnz_taken", pm_if.pm_addr, 8'h12);
    applyStimulus(8'hA3, 0, 1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("jnz_taken_back", pm_if.pm_addr, 8'h10);

    $display("[TB] wrap with wait states");
    guard = 0;
    while (model_pc != 8'hFF && guard < 300) begin
      applyStimulus(8'($urandom), 0, 1'b0, 1'b0, 1'($urandom), 4'($urandom));
      guard++;
    end
    checkOutput("reach_ff", pc, 8'hFF);
    prev_issue = cycle_cnt;
    applyStimulus(8'h3C, 4, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("wait_issue_delay", 8'(issue_cyc - prev_issue), 8'd5);
    checkOutput("wrap_addr", pm_if.pm_addr, 8'h00);

    $display("[TB] timeout and retry");
    pm_if.pm_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checkOutput("to_wait_pm_rd", {7'b0, pm_if.pm_rd}, 8'h01);
      checkOutput("to_wait_err", {7'b0, fetch_err}, 8'h00);
    end
    @(negedge clk);
    checkOutput("retry_pm_rd", {7'b0, pm_if.pm_rd}, 8'h00);
    checkOutput("retry_err", {7'b0, fetch_err}, 8'h01);
    checkOutput("retry_addr", pm_if.pm_addr, 8'h00);
    pm_if.pm_ready = 1'b1;
    pm_if.pm_data  = 8'h99;
    @(negedge clk);
    pm_if.pm_ready = 1'b0;
    checkOutput("rereq_pm_rd", {7'b0, pm_if.pm_rd}, 8'h01);
    checkOutput("rereq_addr", pm_if.pm_addr, 8'h00);
    checkOutput("rereq_valid", {7'b0, instr_valid}, 8'h00);
    checkOutput("rereq_instr", next_instr, BUB);
    exp_err = 1'b1;
    applyStimulus(8'h5E, 1, 1'b1, 1'b0, 1'b0, 4'h7);

    $display("[TB] reset during REQ");
    @(negedge clk);
    pm_if.pm_ready = 1'b1;
    pm_if.pm_data  = 8'h5A;
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_pm_rd", {7'b0, pm_if.pm_rd}, 8'h00);
    checkOutput("midrst_pc", pc, 8'h00);
    checkOutput("midrst_err", {7'b0, fetch_err}, 8'h00);
    checkOutput("midrst_sync", {7'b0, sync_reset}, 8'h01);
    @(negedge clk);
    checkOutput("midrst_valid", {7'b0, instr_valid}, 8'h00);
    checkOutput("midrst_instr", next_instr, BUB);
    pm_if.pm_ready = 1'b0;
    releaseReset();
    applyStimulus(8'h41, 0, 1'b0, 1'b0, 1'b0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetch side of the 8-bit microprocessor: owns the program counter, reads instruction bytes from program memory over a ready handshake, and presents each byte to the instruction decoder on `next_instr` for exactly one clock. It resolves `jmp` and `jmp_nz` coming back from the decoder. It also generates the `sync_reset` the decoder consumes, from the asynchronous system reset.

## Interface
- `BUBBLE`, default 8'hC8: byte driven on `next_instr` whenever no fetched instruction is being issued (decoder NOP).
- `WAIT_LIMIT`, default 15: maximum REQ cycles without `pm_ready` before timeout; 4-bit counter range.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high system reset.
- `jmp` in 1: unconditional jump, from decoder.
- `jmp_nz` in 1: conditional jump, from decoder.
- `dont_jmp` in 1: ALU zero flag; when 1, `jmp_nz` is not taken.
- `ir_nibble` in 4: jump target low nibble, from decoder.
- `pm_ready` in 1: program memory data valid on `pm_data`.
- `pm_data` in 8: program memory read data.
- `pm_addr` out 8: program memory address; equals `pc`.
- `pm_rd` out 1: read request, level, held until `pm_ready`.
- `next_instr` out 8: registered instruction byte to the decoder.
- `instr_valid` out 1: high in the cycle `next_instr` carries a fetched byte.
- `sync_reset` out 1: synchronised reset to the decoder and datapath.
- `pc` out 8: program counter.
- `from_PS` out 8: copy of `pc` for the datapath source mux.
- `fetch_err` out 1: sticky; set on timeout, cleared only by reset.

## Operation
- **Reset values** while `reset` is high: `pc`=0, `pm_rd`=0, `next_instr`=`BUBBLE`, `instr_valid`=0, `fetch_err`=0, `sync_reset`=1, state RST, timeout counter 0.
- **`sync_reset`** is asserted asynchronously. It deasserts through a two-flop chain, so it stays 1 for the first 2 rising edges after `reset` falls.
- **States**
  - RST: holds while `sync_reset`=1, then goes to REQ.
  - REQ: `pm_rd`=1, `pm_addr`=`pc`. If `pm_ready`=1, capture `next_instr`<=`pm_data`, `instr_valid`<=1, go to ISSUE. Otherwise increment the timeout counter.
  - ISSUE: `next_instr` holds the fetched byte. The decoder latches it at the end of this cycle. Go to EXEC, loading `next_instr`<=`BUBBLE`.
  - EXEC: the decoder's `ir` holds the instruction. Sample `jmp`, `jmp_nz`, `dont_jmp`, `ir_nibble` and update `pc` (rules below). Go to REQ.
- **PC update in EXEC**, in priority order:
  - `jmp`=1: `pc`<={`pc`[7:4], `ir_nibble`}.
  - `jmp_nz`=1 and `dont_jmp`=0: same target.
  - Otherwise: `pc`+1, modulo 256 (8'hFF wraps to 8'h00).
- `jmp` and `jmp_nz` are ignored outside EXEC.
- **Timeout**: if the counter reaches `WAIT_LIMIT` in REQ:
  - set `fetch_err`;
  - drop `pm_rd` for one cycle (state RETRY);
  - clear the counter and re-request the same `pc`.
- `pm_ready` outside REQ (including RETRY) is ignored.
- **Reset mid-operation**: any state returns to the reset values immediately. An in-flight `pm_ready` is discarded.

## Timing
- Zero-wait memory (`pm_ready` in the first REQ cycle) gives one instruction per 3 cycles: REQ, ISSUE, EXEC.
- Each memory wait cycle adds 1 cycle.
- `instr_valid` and a non-BUBBLE `next_instr` last exactly 1 cycle per instruction.
- The decoder sees `BUBBLE` in `ir` during all non-EXEC cycles.
- Jump taken or not: no penalty. The next `pm_addr` is valid in the first cycle after EXEC.
- First fetch: `pm_rd`=1 with `pm_addr`=0 in the cycle after `sync_reset` falls.

## Structure
- Shared package `ps_pkg`:
  - state enum (RST, REQ, ISSUE, EXEC, RETRY);
  - `BUBBLE_DEFAULT` = 8'hC8;
  - `PC_W` = 8.
- Sub-module `reset_sync`: two-flop, async-assert / sync-deassert synchroniser producing `sync_reset`.
- Top level contains the FSM, `pc`, the timeout counter and the `next_instr` register.

## Test plan
- **Reset release**: `reset` 1→0 -> `sync_reset` high for 2 edges; first `pm_rd`=1 with `pm_addr`=0x00; `next_instr`=0xC8 throughout.
- **Sequential fetch, zero-wait memory**: ROM 0x00..0x03 = 0x41, 0x52, 0x63, 0x74 -> `next_instr` shows each byte in sequence, spaced exactly 3 cycles apart; `pc` reaches 4.
- **Unconditional jump**: `pc`=0x35, `jmp`=1, `ir_nibble`=0xA in EXEC -> next `pm_addr`=0x3A.
- **Conditional jump, not taken then taken**: `jmp_nz`=1, `dont_jmp`=1 at `pc`=0x10 -> 0x11. Then `dont_jmp`=0 with `ir_nibble`=0x2 -> next `pm_addr`=0x12 taken via the target path; check the counter was not used by also testing `ir_nibble`=0x0 -> 0x10.
- **Wrap and wait states**: `pc`=0xFF, `pm_ready` delayed 4 cycles -> issue occurs 4 cycles later, next `pm_addr`=0x00.
- **Timeout and mid-operation reset**: `pm_ready` held 0 for 15 REQ cycles -> `fetch_err`=1, `pm_rd` low 1 cycle, same address re-requested. Then assert `reset` during REQ -> `pm_rd`=0, `pc`=0, `fetch_err`=0 immediately.
